// File: rtl/f_tran_level.sv
// Dual-rail cell computing F = (A & ~B) | (C & ~D), registered, with a sticky rail-consistency flag.
// Define FTRAN_SWITCH_LEVEL_EN to build the core from nmos/pmos switches instead of a behavioural assign.
module f_tran_level (
  input  logic clk,
  input  logic rst,
  output logic out,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic notA,
  input  logic notB,
  input  logic notC,
  input  logic notD,
  output logic rail_err
);

  logic out_q, out_d;
  logic rail_err_q, rail_err_d;
  logic rail_ok;
  wire  f_core;

  // X or Z on any rail leaves rail_ok unknown, which takes the hold branch below.
  assign rail_ok = (A ^ notA) & (B ^ notB) & (C ^ notC) & (D ^ notD);

`ifdef FTRAN_SWITCH_LEVEL_EN
  supply1 vdd;
  supply0 gnd;
  wire    b_s, d_s;
  wire    pd_mid, pu_ab, pu_cd;

  assign b_s = ~notB;
  assign d_s = ~notD;

  // Pull-down: (notA || B) in series with (notC || D); pull-up is its series/parallel dual.
  nmos n_a (f_core, pd_mid, notA);
  nmos n_b (f_core, pd_mid, b_s);
  nmos n_c (pd_mid, gnd, notC);
  nmos n_d (pd_mid, gnd, d_s);

  pmos p_a (pu_ab, vdd, notA);
  pmos p_b (f_core, pu_ab, b_s);
  pmos p_c (pu_cd, vdd, notC);
  pmos p_d (f_core, pu_cd, d_s);
`else
  assign f_core = (A & notB) | (C & notD);
`endif

  always_comb begin
    out_d      = out_q;
    rail_err_d = rail_err_q;
    if (rail_ok) begin
      out_d = f_core;
    end else begin
      rail_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= 1'b0;
      rail_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      rail_err_q <= rail_err_d;
    end
  end

  assign out      = out_q;
  assign rail_err = rail_err_q;

endmodule

// File: tb/tb_f_tran_level.sv
// Directed bench for f_tran_level: reset, 16-vector sweep, rail fault, sticky flag, async reset.
module tb_f_tran_level;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst;
  logic A, B, C, D, notA, notB, notC, notD;
  logic out, rail_err;

  int n_chk = 0;
  int n_fail = 0;

  // Hand-computed F for ABCD = 0000..1111
  logic exp_out [16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  f_tran_level dut (
    .clk      (clk),
    .rst      (rst),
    .out      (out),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .notA     (notA),
    .notB     (notB),
    .notC     (notC),
    .notD     (notD),
    .rail_err (rail_err)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input logic [3:0] v);
    {A, B, C, D} = v;
    {notA, notB, notC, notD} = ~v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive_valid(4'b1000);
    #2;
    chk("rst_out", out, 1'b0);
    chk("rst_err", rail_err, 1'b0);
    notA = 1'b1;
    #2;
    chk("rst_bad_out", out, 1'b0);
    chk("rst_bad_err", rail_err, 1'b0);
    rst = 1'b0;
    #1;
    clk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive_valid(i[3:0]);
      step();
      chk($sformatf("sweep_out_%0d", i), out, exp_out[i]);
      chk($sformatf("sweep_err_%0d", i), rail_err, 1'b0);
    end

    drive_valid(4'b1000);
    step();
    chk("pre_fault_out", out, 1'b1);
    chk("pre_fault_err", rail_err, 1'b0);

    // A = 1 with notA = 1: out must hold, flag sets
    notA = 1'b1;
    step();
    chk("fault_out_hold", out, 1'b1);
    chk("fault_err", rail_err, 1'b1);

    drive_valid(4'b0010);
    step();
    chk("sticky_out", out, 1'b1);
    chk("sticky_err", rail_err, 1'b1);
    drive_valid(4'b0000);
    step();
    chk("sticky_out0", out, 1'b0);
    chk("sticky_err0", rail_err, 1'b1);

    // Async pulse between edges while out = 1
    drive_valid(4'b1010);
    step();
    chk("pre_rst_out", out, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 1'b0);
    chk("async_rst_err", rail_err, 1'b0);
    #1 rst = 1'b0;
    step();
    chk("resume_out", out, 1'b1);
    chk("resume_err", rail_err, 1'b0);

    // Bad rails sampled while reset is held: reset wins
    #1 rst = 1'b1;
    drive_valid(4'b1000);
    notB = 1'b0;
    step();
    chk("rst_wins_out", out, 1'b0);
    chk("rst_wins_err", rail_err, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_bad_out", out, 1'b0);
    chk("post_rst_bad_err", rail_err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
